// File: rtl/lab3_dg_keyscan_if.sv
// Keypad scanner bus: matrix row/column lines plus the registered key and display-digit outputs.
// The master modport is the scanner side; the slave modport is the keypad/display side.
interface lab3_dg_keyscan_if;
    logic [3:0] row;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    modport master (
        input  row,
        output cols, key_code, key_valid, digit_new, digit_old
    );

    modport slave (
        output row,
        input  cols, key_code, key_valid, digit_new, digit_old
    );
endinterface

// File: rtl/lab3_dg_keyscan.sv
// 4x4 keypad scan controller: column scan, 2-FF row sync, press/release debounce,
// one key_valid pulse per press and a two-digit (newest/previous) key history.
module lab3_dg_keyscan #(
    parameter int SCAN_DIV  = 2400,
    parameter int DB_CYCLES = 480000
) (
    input  logic              clk,
    input  logic              reset,
    lab3_dg_keyscan_if.master bus
);
    localparam int              SW         = $clog2(SCAN_DIV);
    localparam int              DW         = $clog2(DB_CYCLES);
    localparam logic [SW-1:0]   DWELL_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]   SETTLE     = SW'(2);
    localparam logic [DW-1:0]   DB_LAST    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [SW-1:0] r_dwell, w_dwell_nxt;
    logic [DW-1:0] r_db, w_db_nxt;
    logic [1:0]    r_row_sel, w_row_sel_nxt;
    logic [3:0]    r_row_meta, r_rs;
    logic [3:0]    r_key_code, r_digit_new, r_digit_old;
    logic          r_key_valid;
    logic          w_fire;
    logic          w_sel_low;
    logic [1:0]    w_low_row;
    logic [3:0]    w_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    // Lowest-index low row wins when several keys share the driven column.
    always_comb begin
        w_low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_rs[i]) w_low_row = 2'(i);
        end
    end

    assign w_sel_low = ~r_rs[r_row_sel];
    assign w_code    = key_map(r_row_sel, r_idx);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_dwell_nxt   = r_dwell;
        w_db_nxt      = r_db;
        w_row_sel_nxt = r_row_sel;
        w_fire        = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_dwell >= SETTLE && r_rs != 4'hF) begin
                    w_state_nxt   = PRESS_DB;
                    w_row_sel_nxt = w_low_row;
                    w_db_nxt      = '0;
                    w_dwell_nxt   = '0;
                end else if (r_dwell == DWELL_LAST) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_dwell_nxt = '0;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            PRESS_DB: begin
                if (!w_sel_low) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_dwell_nxt = '0;
                    w_db_nxt    = '0;
                end else if (r_db == DB_LAST) begin
                    w_state_nxt = HELD;
                    w_db_nxt    = '0;
                    w_fire      = 1'b1;
                end else begin
                    w_db_nxt = r_db + 1'b1;
                end
            end
            HELD: begin
                if (!w_sel_low) begin
                    w_state_nxt = RELEASE_DB;
                    w_db_nxt    = '0;
                end
            end
            RELEASE_DB: begin
                // A low cycle here is release bounce: back to HELD without a new pulse.
                if (w_sel_low) begin
                    w_state_nxt = HELD;
                    w_db_nxt    = '0;
                end else if (r_db == DB_LAST) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_dwell_nxt = '0;
                    w_db_nxt    = '0;
                end else begin
                    w_db_nxt = r_db + 1'b1;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SCAN;
            r_idx       <= 2'd0;
            r_dwell     <= '0;
            r_db        <= '0;
            r_row_sel   <= 2'd0;
            r_row_meta  <= 4'hF;
            r_rs        <= 4'hF;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_digit_new <= 4'h0;
            r_digit_old <= 4'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_dwell     <= w_dwell_nxt;
            r_db        <= w_db_nxt;
            r_row_sel   <= w_row_sel_nxt;
            r_row_meta  <= bus.row;
            r_rs        <= r_row_meta;
            r_key_valid <= w_fire;
            if (w_fire) begin
                r_key_code  <= w_code;
                r_digit_new <= w_code;
                r_digit_old <= r_digit_new;
            end
        end
    end

    // The column only moves in SCAN, so it stays frozen while a key is being handled.
    assign bus.cols      = ~(4'b0001 << r_idx);
    assign bus.key_code  = r_key_code;
    assign bus.key_valid = r_key_valid;
    assign bus.digit_new = r_digit_new;
    assign bus.digit_old = r_digit_old;
endmodule

// File: tb/tb_lab3_dg_keyscan.sv
// Self-checking bench for lab3_dg_keyscan: keypad matrix model, scoreboard of expected
// key pulses, and timed checks of column freezing, debounce and reset behaviour.
module tb_lab3_dg_keyscan;
    localparam int SCAN_DIV  = 8;
    localparam int DB_CYCLES = 16;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] dnew;
        logic [3:0] dold;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pressed [4];
    logic [3:0] row_drv;
    int         checks    = 0;
    int         errors    = 0;
    int         pulse_cnt = 0;
    exp_t       sb [$];
    exp_t       mon_e;
    logic [3:0] m_new  = 4'h0;
    logic       prev_kv = 1'b0;

    lab3_dg_keyscan_if bus ();

    lab3_dg_keyscan #(
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (|(pressed[r] & ~bus.cols)) row_drv[r] = 1'b0;
        end
    end
    assign bus.row = row_drv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] p;
        p = 4'b1111;
        p[c] = 1'b0;
        return p;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_key(input logic [3:0] code);
        sb.push_back(exp_t'{code: code, dnew: code, dold: m_new});
        m_new = code;
    endtask

    task automatic wait_pulse(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (pulse_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, pulse_cnt, target);
    endtask

    task automatic wait_cols(input logic [3:0] want, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.cols !== want && n < budget) begin
            step(1);
            n++;
        end
        check(tag, bus.cols, want);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    // Scoreboard side: every key_valid pulse pops one expected key.
    always @(negedge clk) begin
        if (!reset && bus.key_valid) begin
            check("kv_one_cycle", prev_kv, 1'b0);
            pulse_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_pulse_code", bus.key_code, 32'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                check("key_code", bus.key_code, mon_e.code);
                check("digit_new", bus.digit_new, mon_e.dnew);
                check("digit_old", bus.digit_old, mon_e.dold);
            end
        end
        prev_kv = bus.key_valid && !reset;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        release_all();
        reset = 1'b1;
        step(3);
        check("rst_cols", bus.cols, 4'b1110);
        check("rst_key_code", bus.key_code, 4'h0);
        check("rst_key_valid", bus.key_valid, 1'b0);
        check("rst_digit_new", bus.digit_new, 4'h0);
        check("rst_digit_old", bus.digit_old, 4'h0);

        // Idle scan: each column held for SCAN_DIV cycles, wrapping after column 3.
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("idle_cols", bus.cols, col_pat((i / SCAN_DIV) % 4));
        end
        step(1);

        // Key '5': one pulse, column frozen until release plus debounce.
        expect_key(4'h5);
        pressed[1][1] = 1'b1;
        wait_pulse(1, 100, "k5_pulse");
        step(30);
        check("k5_frozen", bus.cols, col_pat(1));
        check("k5_code_held", bus.key_code, 4'h5);
        pressed[1][1] = 1'b0;
        step(18);
        check("k5_release_frozen", bus.cols, col_pat(1));
        step(2);
        check("k5_release_next", bus.cols, col_pat(2));

        // Key 'D' shifts '5' into the old digit.
        expect_key(4'hD);
        pressed[3][3] = 1'b1;
        wait_pulse(2, 100, "kD_pulse");
        step(5);
        release_all();
        step(25);

        // Press bounce on '6': 5 low / 1 high never completes debounce.
        wait_cols(col_pat(1), 64, "bounce_sync1");
        wait_cols(col_pat(2), 64, "bounce_sync2");
        step(2);
        for (int i = 0; i < 60; i++) begin
            pressed[1][2] = ((i % 6) != 5);
            if (i == 7) check("bounce_frozen", bus.cols, col_pat(2));
            if (i == 8) check("bounce_next_col", bus.cols, col_pat(3));
            step(1);
        end
        release_all();
        step(5);
        check("bounce_no_pulse", pulse_cnt, 2);

        // Release bounce on '8': one-cycle glitch restarts release debounce.
        expect_key(4'h8);
        pressed[2][1] = 1'b1;
        wait_pulse(3, 100, "k8_pulse");
        step(5);
        pressed[2][1] = 1'b0;
        step(8);
        pressed[2][1] = 1'b1;
        step(1);
        pressed[2][1] = 1'b0;
        step(13);
        check("relbounce_frozen", bus.cols, col_pat(1));
        step(8);
        check("relbounce_next", bus.cols, col_pat(2));

        // Hold '5', then add '9' in another column: ignored.
        expect_key(4'h5);
        pressed[1][1] = 1'b1;
        wait_pulse(4, 100, "k5b_pulse");
        pressed[2][2] = 1'b1;
        step(40);
        check("two_key_frozen", bus.cols, col_pat(1));
        check("two_key_no_pulse", pulse_cnt, 4);
        release_all();
        step(25);

        // 'A' (col3) and '3' (col2) together: col2 is scanned first.
        wait_cols(col_pat(0), 64, "ab_sync");
        pressed[0][3] = 1'b1;
        pressed[0][2] = 1'b1;
        expect_key(4'h3);
        wait_pulse(5, 100, "k3_pulse");
        step(20);
        check("k3_frozen", bus.cols, col_pat(2));
        release_all();
        step(25);

        // '2' and '5' share col1: lowest row wins.
        wait_cols(col_pat(0), 64, "same_col_sync");
        pressed[0][1] = 1'b1;
        pressed[1][1] = 1'b1;
        expect_key(4'h2);
        wait_pulse(6, 100, "k2_pulse");
        step(5);
        release_all();
        step(25);

        // Reset while '7' is held: asynchronous clear, then a fresh press cycle.
        expect_key(4'h7);
        pressed[2][0] = 1'b1;
        wait_pulse(7, 100, "k7_pulse");
        step(5);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cols", bus.cols, 4'b1110);
        check("midrst_key_code", bus.key_code, 4'h0);
        check("midrst_key_valid", bus.key_valid, 1'b0);
        check("midrst_digit_new", bus.digit_new, 4'h0);
        check("midrst_digit_old", bus.digit_old, 4'h0);
        m_new = 4'h0;
        expect_key(4'h7);
        step(3);
        reset = 1'b0;
        wait_pulse(8, 100, "k7_after_rst_pulse");
        step(5);
        release_all();
        step(50);

        check("sb_empty", sb.size(), 0);
        check("total_pulses", pulse_cnt, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lab3_dg_keyscan.md
Name: lab3_dg_keyscan

Overview:
Scan-sequencing controller for the 4x4 keypad matrix. It drives the column lines, samples the row lines, debounces the key, and registers exactly one keypress per physical press. It also keeps a two-digit history (newest and previous key) that feeds the seven-segment decoder and display-mux datapath in lab3_dg_top. Runs entirely in the int_osc domain.

Parameters:
SCAN_DIV, 2400, clock cycles each column is driven during scanning (>=4)
DB_CYCLES, 480000, consecutive stable cycles required for press or release debounce (>=2)

Ports:
clk  input  1  system clock (int_osc)
reset  input  1  asynchronous reset, active-high
row  input  4  keypad row lines, active-low (pulled up; pressed key pulls its row low when its column is driven)
cols  output  4  keypad column drive, active-low one-cold
key_code  output  4  hex code of last registered key
key_valid  output  1  one-cycle pulse when a new key is registered
digit_new  output  4  most recent key code (right display digit)
digit_old  output  4  previous key code (left display digit)

Behaviour:
- Reset (async, active-high) values: cols=4'b1110, key_code=0, key_valid=0, digit_new=0, digit_old=0, state=SCAN, column index=0, all counters=0, row synchronizer=4'hF.
- row passes through a 2-FF synchronizer (rs). All decisions use rs. Input-to-decision latency is 2 cycles.
- Key map, [row][col]: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - cols = ~(1<<idx). The dwell counter counts 0..SCAN_DIV-1.
  - At dwell = SCAN_DIV-1: idx advances (3 wraps to 0) and dwell clears.
  - For dwell >= 2 (settle window), if rs != 4'hF: latch idx and the lowest-index low row, clear the debounce counter, and go to PRESS_DB. The column freezes.
- PRESS_DB:
  - Column stays frozen. Each cycle the latched row is low, db increments.
  - If the latched row reads high, return to SCAN with idx+1 and dwell=0. No pulse is issued.
  - When db reaches DB_CYCLES-1 with the row still low, go to HELD. On that transition the next cycle shows:
    - key_valid=1;
    - key_code = map[row][col];
    - digit_old <= digit_new;
    - digit_new <= code.
- HELD:
  - Column frozen. Other rows/keys are ignored, so no additional pulses occur.
  - When the latched row reads high, clear db and go to RELEASE_DB.
- RELEASE_DB:
  - Each high cycle, db increments. A low cycle returns to HELD with no new pulse (bounce).
  - When db reaches DB_CYCLES-1, go to SCAN with idx+1.
- key_valid is high for exactly 1 cycle per registered press. key_code, digit_new and digit_old hold their values otherwise.
- Multiple simultaneous keys:
  - Same column: the lowest row index wins.
  - Different columns: the first column scanned wins.
  - Keys in other columns are invisible while the column is frozen.
- Reset mid-operation (any state) returns immediately to the reset values. No pulse is issued on reset release.
- Counter widths are sized by $clog2 of the parameters. There is no overflow because counters clear on every state change.

Test Plan:
(SCAN_DIV=8, DB_CYCLES=16 for all)
- Reset held, then released with no key -> cols cycles 1110, 1101, 1011, 0111, 1110, each for 8 cycles; key_valid never asserted.
- Key '5' (row1 pulled low while cols=1101) held for 40 cycles -> exactly one key_valid pulse about 18 cycles after detection; key_code=5, digit_new=5, digit_old=0; cols stays 1101 until release plus 16 high cycles.
- Press '5', release, then press 'D' (row3/col3) -> second pulse with key_code=D, digit_new=D, digit_old=5.
- Bounce: row toggles low 5 cycles / high 1 cycle during PRESS_DB -> no pulse, scan resumes at the next column. Release bounce (1-cycle low glitch in RELEASE_DB) -> returns to HELD, still only one pulse total.
- Two keys: hold '5', then additionally press '9' (row2, col2) -> no second pulse. With 'A' and '3' pressed together before the scan reaches them (same column col3 for r0 A; 3 is col2) -> '3' is registered first (col2 is scanned before col3).
- Assert reset during HELD after the '7' pulse -> outputs go to 0 and cols to 1110 asynchronously; after deassert, while '7' is still held, a fresh press cycle registers 7 once.
